// File: rtl/seg7_pkg.sv
// Shared types and helpers for the scanned 7-segment display.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter.
// One capture cycle, W shift cycles, one commit cycle, then a done pulse.
module seg7_bcd_conv
    import seg7_pkg::*;
#(
    parameter int W      = 5,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [W-1:0]        bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    state_t        state_q, state_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [BW-1:0] adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        adj     = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_disp.sv
// Load-strobed binary value -> BCD -> time-multiplexed active-low 7-seg digits.
// Optional SEG_BLINK_EN adds blink_i and BLINK_DIV (frames per blink phase).
module seg7_scan_disp
    import seg7_pkg::*;
#(
    parameter int W           = 5,
    parameter int DIGITS      = 2,
    parameter int MIN_VAL     = 1,
    parameter int MAX_VAL     = 12,
    parameter int REFRESH_DIV = 50000,
    parameter int ZERO_PAD    = 1
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_DIV   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      value_i,
    input  logic              load_i,
`ifdef SEG_BLINK_EN
    input  logic              blink_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [6:0]        seg_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "seg7_scan_disp: DIGITS must be 1..8");
    end
    if (MAX_VAL >= 10**DIGITS || MAX_VAL >= 2**W) begin : g_bad_max
        $fatal(1, "seg7_scan_disp: MAX_VAL does not fit W/DIGITS");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $fatal(1, "seg7_scan_disp: REFRESH_DIV must be >= 2");
    end

    logic          start;
    logic          conv_busy;
    logic          conv_done;
    logic [BW-1:0] conv_bcd;
    logic          in_range_q;
    logic [BW-1:0] disp_q;
    logic [BW-1:0] disp_new;
    logic          lead;
    logic [PW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic          tick;
    logic [DIGITS-1:0] an_d;
    logic          seg_on;

    assign start = load_i & ~conv_busy;

    seg7_bcd_conv #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (value_i),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Leading-zero suppression walks down from the top digit; digit 0 always shows.
    always_comb begin
        disp_new = conv_bcd;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead && (conv_bcd[4*i +: 4] == 4'd0);
            if (lead && ZERO_PAD == 0)
                disp_new[4*i +: 4] = DIGIT_BLANK;
        end
        if (!in_range_q)
            disp_new = {DIGITS{DIGIT_BLANK}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_range_q <= 1'b0;
            disp_q     <= {DIGITS{DIGIT_BLANK}};
            done_o     <= 1'b0;
        end else begin
            if (start)
                in_range_q <= (value_i >= W'(MIN_VAL)) &&
                              (value_i <= W'(MAX_VAL));
            if (conv_done)
                disp_q <= disp_new;
            done_o <= conv_done;
        end
    end

    assign tick   = (pre_q == PW'(REFRESH_DIV - 1));
    assign busy_o = conv_busy;

    always_comb begin
        an_d = '1;
        for (int i = 0; i < DIGITS; i++)
            an_d[i] = (idx_q != IW'(i));
    end

`ifdef SEG_BLINK_EN
    localparam int FW = $clog2(BLINK_DIV + 1);

    logic [FW-1:0] frame_q;
    logic          phase_q;
    logic          frame_end;

    assign frame_end = tick && (idx_q == IW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= '0;
            phase_q <= 1'b1;
        end else if (!blink_i) begin
            frame_q <= '0;
            phase_q <= 1'b1;
        end else if (frame_end) begin
            if (frame_q == FW'(BLINK_DIV - 1)) begin
                frame_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                frame_q <= frame_q + FW'(1);
            end
        end
    end

    assign seg_on = phase_q;
`else
    assign seg_on = 1'b1;
`endif

    // Outputs latch the current slot, then the index moves on for the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            an_o  <= '1;
            seg_o <= SEG_BLANK;
        end else if (tick) begin
            pre_q <= '0;
            an_o  <= an_d;
            seg_o <= seg_on ? seg7_encode(disp_q[4*idx_q +: 4]) : SEG_BLANK;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Scoreboard bench: zero-padded and blank-padded instances share one stimulus stream.
// A decimal reference model predicts busy, done latency and every scanned slot.
module tb_seg7_scan_disp;

    localparam int W   = 5;
    localparam int DG  = 2;
    localparam int MN  = 1;
    localparam int MX  = 12;
    localparam int DIV = 4;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] value = '0;
    logic         load = 1'b0;

    logic         busy_p, done_p, busy_n, done_n;
    logic [6:0]   seg_p, seg_n;
    logic [DG-1:0] an_p, an_n;

    always #5 clk = ~clk;

    seg7_scan_disp #(
        .W(W), .DIGITS(DG), .MIN_VAL(MN), .MAX_VAL(MX),
        .REFRESH_DIV(DIV), .ZERO_PAD(1)
    ) u_pad (
        .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
        .busy_o(busy_p), .done_o(done_p), .seg_o(seg_p), .an_o(an_p)
    );

    seg7_scan_disp #(
        .W(W), .DIGITS(DG), .MIN_VAL(MN), .MAX_VAL(MX),
        .REFRESH_DIV(DIV), .ZERO_PAD(0)
    ) u_nopad (
        .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
        .busy_o(busy_n), .done_o(done_n), .seg_o(seg_n), .an_o(an_n)
    );

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_left = 0;
    int   scan_cnt = 0;
    int   cur_val = -1;
    int   held_slot = -1;
    int   held_val = -1;
    bit   started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    // v < 0 means a blank display; otherwise the decimal digit at position d.
    function automatic logic [6:0] exp_seg(input int v, input int d,
                                           input bit pad);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (v < 0) return 7'b1111111;
        if (!pad && d > 0 && v < p) return 7'b1111111;
        return digit_seg((v / p) % 10);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            started   = 1'b1;
            busy_left = 0;
            sb.delete();
            cur_val   = -1;
            scan_cnt  = 0;
            held_slot = -1;
            held_val  = -1;
        end else begin
            scan_cnt++;
            if (scan_cnt % DIV == 0) begin
                held_slot = (scan_cnt / DIV - 1) % DG;
                held_val  = cur_val;
            end
            if (load && busy_left == 0) begin
                sb.push_back('{cyc: cyc,
                    val: (int'(value) >= MN && int'(value) <= MX) ?
                         int'(value) : -1});
                busy_left = W + 1;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
    end

    always @(negedge clk) begin
        logic [DG-1:0] exp_an;
        logic [6:0]    sp, sn;
        bit            due;
        exp_t          e;
        if (started) begin
            exp_an = '1;
            sp = 7'b1111111;
            sn = 7'b1111111;
            if (held_slot >= 0) begin
                exp_an[held_slot] = 1'b0;
                sp = exp_seg(held_val, held_slot, 1'b1);
                sn = exp_seg(held_val, held_slot, 1'b0);
            end
            chk("busy_pad", busy_p, busy_left > 0);
            chk("busy_nopad", busy_n, busy_left > 0);
            chk("an_pad", an_p, exp_an);
            chk("an_nopad", an_n, exp_an);
            chk("seg_pad", seg_p, sp);
            chk("seg_nopad", seg_n, sn);
            due = (sb.size() > 0) && (cyc == sb[0].cyc + LAT);
            chk("done_nopad", done_n, due);
            if (done_p) begin
                if (sb.size() == 0) begin
                    chk("done_spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - e.cyc, LAT);
                    cur_val = e.val;
                end
            end else if (sb.size() > 0 && cyc >= sb[0].cyc + LAT) begin
                chk("done_timeout", 0, 1);
                e = sb.pop_front();
                cur_val = e.val;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int v);
        value = W'(v);
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        step(10);
        do_load(7);
        step(20);
        do_load(12);
        step(20);
        do_load(0);
        step(12);
        do_load(13);
        step(12);
        do_load(3);
        step(1);
        do_load(9);
        step(20);
        do_load(5);
        step(20);
        do_load(10);
        step(20);
        do_load(11);
        step(20);
        do_load(6);
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(12);
        repeat (200) begin
            value = W'($urandom_range(0, 31));
            load  = ($urandom_range(0, 3) != 0);
            step($urandom_range(1, 10));
            load  = 1'b0;
            step($urandom_range(0, 8));
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
        end
        step(40);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
